// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Requester side of the instruction-memory block-read handshake. Takes a
// single-block miss from the L1 I-cache, holds mem_ren and the block address
// stable until the memory answers, captures the returned block and writes it
// into the cache line with a one-cycle fill strobe. A flush (abort) cancels an
// outstanding read. A watchdog gives up on a memory that never answers and
// leaves a sticky error flag behind.
// Every output is a register, so no input reaches an output combinationally.
module icache_refill_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int BLOCK_W   = 128,
  parameter int INDEX_W   = 5,
  parameter int TIMEOUT_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss,
  input  logic [ADDR_W-1:0]         miss_block_addr,
  input  logic                      abort,
  output logic                      busy,
  output logic                      mem_ren,
  output logic [ADDR_W-1:0]         mem_block_address,
  input  logic                      mem_ready,
  input  logic [BLOCK_W-1:0]        mem_dout,
  output logic                      fill_we,
  output logic [INDEX_W-1:0]        fill_index,
  output logic [ADDR_W-INDEX_W-1:0] fill_tag,
  output logic [BLOCK_W-1:0]        fill_data,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } state_t;

  // The watchdog gives up once the incremented count reaches all-ones, which
  // allows 2^TIMEOUT_W-1 WAIT cycles for the memory to answer.
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = {TIMEOUT_W{1'b1}};

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [TIMEOUT_W-1:0] watchdog;
  logic [TIMEOUT_W-1:0] watchdog_inc;
  logic                wd_expired;

  // Next watchdog value and whether this WAIT cycle is the last one allowed
  always_comb begin
    watchdog_inc = watchdog + TIMEOUT_W'(1);
    wd_expired   = (watchdog_inc == WD_LIMIT);
  end

  // Refill FSM with all outputs registered alongside the state
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      addr_q            <= '0;
      watchdog          <= '0;
      busy              <= 1'b0;
      mem_ren           <= 1'b0;
      mem_block_address <= '0;
      fill_we           <= 1'b0;
      done              <= 1'b0;
      fill_index        <= '0;
      fill_tag          <= '0;
      fill_data         <= '0;
      err               <= 1'b0;
    end else begin
      fill_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          // abort together with miss drops the miss; mem_ready is ignored here
          if (miss && !abort) begin
            addr_q            <= miss_block_addr;
            mem_block_address <= miss_block_addr;
            watchdog          <= '0;
            mem_ren           <= 1'b1;
            busy              <= 1'b1;
            state             <= WAIT;
          end
        end

        WAIT: begin
          watchdog <= watchdog_inc;
          if (abort) begin
            // Flush wins over a same-cycle memory answer
            mem_ren <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (mem_ready) begin
            // A same-cycle answer wins over the watchdog
            fill_data  <= mem_dout;
            fill_index <= addr_q[INDEX_W-1:0];
            fill_tag   <= addr_q[ADDR_W-1:INDEX_W];
            fill_we    <= 1'b1;
            done       <= 1'b1;
            mem_ren    <= 1'b0;
            state      <= FILL;
          end else if (wd_expired) begin
            err     <= 1'b1;
            mem_ren <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        FILL: begin
          // The fill strobe is already out and cannot be cancelled. The edge
          // closing FILL also serves as the IDLE miss sample, so a held miss
          // restarts the read after exactly one ren-low cycle.
          if (miss && !abort) begin
            addr_q            <= miss_block_addr;
            mem_block_address <= miss_block_addr;
            watchdog          <= '0;
            mem_ren           <= 1'b1;
            busy              <= 1'b1;
            state             <= WAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          mem_ren <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl
// Directed bench for icache_refill_ctrl. Expected fills are queued when a miss
// is issued; a negedge monitor pops and compares whenever fill_we is seen.
module tb_icache_refill_ctrl;

  localparam int ADDR_W    = 10;
  localparam int BLOCK_W   = 128;
  localparam int INDEX_W   = 5;
  localparam int TIMEOUT_W = 4;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      miss;
  logic [ADDR_W-1:0]         miss_block_addr;
  logic                      abort;
  logic                      busy;
  logic                      mem_ren;
  logic [ADDR_W-1:0]         mem_block_address;
  logic                      mem_ready;
  logic [BLOCK_W-1:0]        mem_dout;
  logic                      fill_we;
  logic [INDEX_W-1:0]        fill_index;
  logic [ADDR_W-INDEX_W-1:0] fill_tag;
  logic [BLOCK_W-1:0]        fill_data;
  logic                      done;
  logic                      err;

  typedef struct {
    logic [INDEX_W-1:0]        idx;
    logic [ADDR_W-INDEX_W-1:0] tag;
    logic [BLOCK_W-1:0]        data;
  } fill_t;

  fill_t exp_q[$];
  fill_t mon_exp;
  int    tests_run    = 0;
  int    tests_failed = 0;

  icache_refill_ctrl #(
    .ADDR_W   (ADDR_W),
    .BLOCK_W  (BLOCK_W),
    .INDEX_W  (INDEX_W),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .miss             (miss),
    .miss_block_addr  (miss_block_addr),
    .abort            (abort),
    .busy             (busy),
    .mem_ren          (mem_ren),
    .mem_block_address(mem_block_address),
    .mem_ready        (mem_ready),
    .mem_dout         (mem_dout),
    .fill_we          (fill_we),
    .fill_index       (fill_index),
    .fill_tag         (fill_tag),
    .fill_data        (fill_data),
    .done             (done),
    .err              (err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every fill strobe must match the oldest queued fill
  always @(negedge clock) begin
    if (fill_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_fill: got fill_we=1 index=%0h, expected no fill at %0t", fill_index, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("sb_fill_index", 128'(fill_index), 128'(mon_exp.idx));
        checkOutput("sb_fill_tag", 128'(fill_tag), 128'(mon_exp.tag));
        checkOutput("sb_fill_data", fill_data, mon_exp.data);
        checkOutput("sb_done", 128'(done), 128'd1);
      end
    end
  end

  // One complete refill: miss, (delay+1) WAIT cycles with ready on the last, FILL, IDLE
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [BLOCK_W-1:0] data,
                               input int delay, input logic [INDEX_W-1:0] eidx,
                               input logic [ADDR_W-INDEX_W-1:0] etag);
    exp_q.push_back('{idx: eidx, tag: etag, data: data});
    miss            = 1'b1;
    miss_block_addr = addr;
    tick();
    miss = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      checkOutput("wait_mem_ren", 128'(mem_ren), 128'd1);
      checkOutput("wait_addr", 128'(mem_block_address), 128'(addr));
      checkOutput("wait_busy", 128'(busy), 128'd1);
      if (i == delay) begin
        mem_ready = 1'b1;
        mem_dout  = data;
      end
      tick();
    end
    mem_ready = 1'b0;
    mem_dout  = '0;
    checkOutput("fill_mem_ren", 128'(mem_ren), 128'd0);
    checkOutput("fill_we", 128'(fill_we), 128'd1);
    checkOutput("fill_done", 128'(done), 128'd1);
    tick();
    checkOutput("after_busy", 128'(busy), 128'd0);
    checkOutput("after_fill_we", 128'(fill_we), 128'd0);
  endtask

  initial begin
    reset           = 1'b1;
    miss            = 1'b1;
    miss_block_addr = 10'h2A5;
    abort           = 1'b0;
    mem_ready       = 1'b0;
    mem_dout        = '0;

    // Reset dominates a pending miss
    tick();
    tick();
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_mem_ren", 128'(mem_ren), 128'd0);
    checkOutput("rst_fill_we", 128'(fill_we), 128'd0);
    checkOutput("rst_done", 128'(done), 128'd0);
    checkOutput("rst_err", 128'(err), 128'd0);
    checkOutput("rst_addr", 128'(mem_block_address), 128'd0);
    checkOutput("rst_fill_data", fill_data, 128'd0);
    checkOutput("rst_fill_index", 128'(fill_index), 128'd0);
    checkOutput("rst_fill_tag", 128'(fill_tag), 128'd0);
    miss  = 1'b0;
    reset = 1'b0;
    tick();

    // Basic refill, D=3
    applyStimulus(10'h2A5, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 3, 5'h05, 5'h15);
    checkOutput("basic_data_hold", fill_data, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);

    // Back-to-back misses with miss held high
    exp_q.push_back('{idx: 5'h01, tag: 5'h00, data: 128'hAAAA_0000_1111_2222_3333_4444_5555_6666});
    exp_q.push_back('{idx: 5'h1F, tag: 5'h1F, data: 128'hBBBB_7777_8888_9999_CCCC_DDDD_EEEE_FFFF});
    miss            = 1'b1;
    miss_block_addr = 10'h001;
    tick();
    checkOutput("b2b_ren1", 128'(mem_ren), 128'd1);
    checkOutput("b2b_addr1", 128'(mem_block_address), 128'h001);
    mem_ready = 1'b1;
    mem_dout  = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    tick();
    mem_ready       = 1'b0;
    miss_block_addr = 10'h3FF;
    checkOutput("b2b_fill_ren", 128'(mem_ren), 128'd0);
    checkOutput("b2b_fill_we1", 128'(fill_we), 128'd1);
    tick();
    miss = 1'b0;
    checkOutput("b2b_ren2", 128'(mem_ren), 128'd1);
    checkOutput("b2b_addr2", 128'(mem_block_address), 128'h3FF);
    mem_ready = 1'b1;
    mem_dout  = 128'hBBBB_7777_8888_9999_CCCC_DDDD_EEEE_FFFF;
    tick();
    mem_ready = 1'b0;
    checkOutput("b2b_fill_we2", 128'(fill_we), 128'd1);
    tick();
    checkOutput("b2b_busy_end", 128'(busy), 128'd0);

    // Abort in the 2nd WAIT cycle together with mem_ready
    miss            = 1'b1;
    miss_block_addr = 10'h155;
    tick();
    miss = 1'b0;
    tick();
    abort     = 1'b1;
    mem_ready = 1'b1;
    mem_dout  = 128'hDEAD_BEEF;
    tick();
    abort     = 1'b0;
    mem_ready = 1'b0;
    checkOutput("abort_ren", 128'(mem_ren), 128'd0);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_fill_we", 128'(fill_we), 128'd0);
    checkOutput("abort_done", 128'(done), 128'd0);

    // miss together with abort in IDLE is dropped
    miss  = 1'b1;
    abort = 1'b1;
    tick();
    miss  = 1'b0;
    abort = 1'b0;
    checkOutput("missabort_busy", 128'(busy), 128'd0);
    checkOutput("missabort_ren", 128'(mem_ren), 128'd0);
    tick();
    checkOutput("missabort_busy2", 128'(busy), 128'd0);

    // Timeout: 15 WAIT cycles with no answer
    miss            = 1'b1;
    miss_block_addr = 10'h0AA;
    tick();
    miss = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checkOutput("to_wait_ren", 128'(mem_ren), 128'd1);
      checkOutput("to_wait_err", 128'(err), 128'd0);
      tick();
    end
    checkOutput("to_err", 128'(err), 128'd1);
    checkOutput("to_busy", 128'(busy), 128'd0);
    checkOutput("to_ren", 128'(mem_ren), 128'd0);
    checkOutput("to_fill_we", 128'(fill_we), 128'd0);

    // A later miss still completes and err stays set
    applyStimulus(10'h3C3, 128'h5A5A_5A5A_0F0F_0F0F_1234_5678_9ABC_DEF0, 2, 5'h03, 5'h1E);
    checkOutput("to_err_sticky", 128'(err), 128'd1);

    // Reset clears err, then ready on the 15th WAIT cycle beats the timeout
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst2_err", 128'(err), 128'd0);
    applyStimulus(10'h111, 128'hFEED_FACE_CAFE_F00D_0000_1111_2222_3333, 14, 5'h11, 5'h08);
    checkOutput("race_err", 128'(err), 128'd0);

    tick();
    tick();
    checkOutput("sb_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
